score_display_mux: RTL and testbench

SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

---
 rtl/score_disp_pkg.sv | 43 ++++
 rtl/score_display_mux_bin2bcd.sv | 90 +++++++++
 rtl/score_display_mux.sv | 133 +++++++++++++
 tb/tb_score_display_mux.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// score_disp_pkg: shared types and 7-segment patterns
// for the multiplexed score display.
package score_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE
    } conv_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/score_display_mux_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per
// cycle, saturating to all-nines when the value does not fit.
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [VAL_W-1:0]      value_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [4*DIGITS-1:0]   bcd_o
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam logic [63:0] MAXV = 64'(10 ** DIGITS - 1);

    conv_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [VAL_W-1:0]  sh_q;
    logic [BCD_W-1:0]  acc_q;
    logic [BCD_W-1:0]  adj_d;
    logic              sat_q;
    logic              done_q;
    logic              busy_q;

    // Add 3 to every BCD digit of 5 or more before the next shift
    always_comb begin
        adj_d = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj_d[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = adj_d[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM with registered done/busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    sh_q    <= value_i;
                    acc_q   <= '0;
                    sat_q   <= 64'(value_i) > MAXV;
                    cnt_q   <= '0;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc_q <= {adj_d[BCD_W-2:0], sh_q[VAL_W-1]};
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(VAL_W - 1)) begin
                        state_q <= S_STORE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_STORE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done_o = done_q;
    assign busy_o = busy_q;
    assign bcd_o  = sat_q ? {DIGITS{4'h9}} : acc_q;

endmodule

// File: rtl/score_display_mux.sv
// score_display_mux: multiplexed 7-segment score display with
// round-robin BCD conversion, leading-zero blanking and blink.
module score_display_mux
    import score_disp_pkg::*;
#(
    parameter int FIELDS      = 2,
    parameter int DIGITS      = 4,
    parameter int VAL_W       = 14,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FIELDS*VAL_W-1:0] values,
    input  logic [FIELDS-1:0]       blank_lz,
    input  logic [FIELDS-1:0]       blink,
    output logic [6:0]              cathode,
    output logic [7:0]              AN,
    output logic                    busy
);
    localparam int N     = FIELDS * DIGITS;
    localparam int BCD_W = 4 * DIGITS;
    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int FP_W  = (FIELDS > 1) ? $clog2(FIELDS) : 1;

    logic [PS_W-1:0]  presc_q;
    logic             slot_tick;
    logic [2:0]       idx_q;
    logic             frame_wrap;
    logic [BL_W-1:0]  frm_q;
    logic             phase_q;
    logic             lit_q;
    logic [FP_W-1:0]  fptr_q;
    logic [BCD_W-1:0] disp_q [FIELDS];
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [6:0]       cathode_q;
    logic [7:0]       an_q;

    logic [FP_W-1:0]  cur_f;
    logic [2:0]       cur_d;
    logic [BCD_W-1:0] upper;
    logic             lz_blank;
    logic [6:0]       cathode_d;
    logic [7:0]       an_d;

    assign slot_tick  = (presc_q == PS_W'(REFRESH_DIV - 1));
    assign frame_wrap = slot_tick && (idx_q == 3'(N - 1));

    // Prescaler, digit scan, frame/blink counters, first-lit flag
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            phase_q <= 1'b0;
            lit_q   <= 1'b0;
        end else begin
            presc_q <= slot_tick ? '0 : presc_q + 1'b1;
            if (slot_tick) begin
                lit_q <= 1'b1;
                idx_q <= frame_wrap ? '0 : idx_q + 1'b1;
            end
            if (frame_wrap) begin
                if (frm_q == BL_W'(BLINK_DIV - 1)) begin
                    frm_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    frm_q <= frm_q + 1'b1;
                end
            end
        end
    end

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (1'b1),
        .value_i (values[fptr_q*VAL_W +: VAL_W]),
        .done_o  (conv_done),
        .busy_o  (busy),
        .bcd_o   (conv_bcd)
    );

    // Capture finished conversions and step to the next field
    always_ff @(posedge clk) begin
        if (rst) begin
            fptr_q <= '0;
            for (int f = 0; f < FIELDS; f++) begin
                disp_q[f] <= '0;
            end
        end else if (conv_done) begin
            disp_q[fptr_q] <= conv_bcd;
            if (fptr_q == FP_W'(FIELDS - 1)) begin
                fptr_q <= '0;
            end else begin
                fptr_q <= fptr_q + 1'b1;
            end
        end
    end

    // Select, blank and decode the digit under the scan index
    always_comb begin
        cur_f    = FP_W'(int'(idx_q) / DIGITS);
        cur_d    = 3'(int'(idx_q) % DIGITS);
        upper    = disp_q[cur_f] >> {cur_d, 2'b00};
        lz_blank = blank_lz[cur_f] && (cur_d != 3'd0) && (upper == '0);
        cathode_d = lz_blank ? SEG_BLANK : seg_decode(upper[3:0]);
        an_d = 8'hFF;
        if (!(blink[cur_f] && phase_q)) begin
            an_d[idx_q] = 1'b0;
        end
    end

    // Register the drive so cathode and anodes switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            cathode_q <= SEG_BLANK;
            an_q      <= 8'hFF;
        end else if (lit_q) begin
            cathode_q <= cathode_d;
            an_q      <= an_d;
        end
    end

    assign cathode = cathode_q;
    assign AN      = an_q;

endmodule

// File: tb/tb_score_display_mux.sv
// tb_score_display_mux: scoreboard bench; stimulus queues expected
// per-slot drive, a monitor compares at the middle of each slot.
module tb_score_display_mux;

    localparam int FIELDS = 2;
    localparam int DIGITS = 4;
    localparam int VAL_W  = 14;
    localparam int RDIV   = 4;
    localparam int BDIV   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [FIELDS*VAL_W-1:0] values;
    logic [FIELDS-1:0]       blank_lz;
    logic [FIELDS-1:0]       blink;
    logic [6:0]              cathode;
    logic [7:0]              AN;
    logic                    busy;

    score_display_mux #(
        .FIELDS      (FIELDS),
        .DIGITS      (DIGITS),
        .VAL_W       (VAL_W),
        .REFRESH_DIV (RDIV),
        .BLINK_DIV   (BDIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .values   (values),
        .blank_lz (blank_lz),
        .blink    (blink),
        .cathode  (cathode),
        .AN       (AN),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         slot;
        logic [7:0] an;
        logic [6:0] cath;
    } exp_t;

    typedef struct {
        int          v0;
        int          v1;
        logic [1:0]  blz;
        logic [1:0]  blk;
        logic [31:0] dig;
        int          frames;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vecs[6];
    logic [6:0] seg_tab[11];
    int         errors = 0;
    int         checks = 0;
    int         ecount = 0;
    int         cur_slot = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] an,
                        input logic [6:0] c);
        exp_t e;
        e.slot = s;
        e.an   = an;
        e.cath = c;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d slots pending, expected 0",
                     sbq.size());
            sbq.delete();
        end
    endtask

    // Queue expected anode/cathode drive for whole frames
    task automatic run_vec(input vec_t v);
        int s0;
        int s;
        logic [3:0] code;
        logic [7:0] an;
        logic [7:0] one;
        values   = {VAL_W'(v.v1), VAL_W'(v.v0)};
        blank_lz = v.blz;
        blink    = v.blk;
        repeat (60) @(negedge clk);
        s0 = (cur_slot / 8 + 2) * 8;
        for (int fr = 0; fr < v.frames; fr++) begin
            for (int k = 0; k < 8; k++) begin
                s    = s0 + fr * 8 + k;
                code = v.dig[4*k +: 4];
                one  = 8'h01 << k;
                if (((s / (8 * BDIV)) % 2 == 1) && v.blk[k / 4]) begin
                    an = 8'hFF;
                end else begin
                    an = ~one;
                end
                push(s, an, seg_tab[code]);
            end
        end
        drain();
    endtask

    // Monitor: slot timebase from reset release, compare mid-slot
    initial begin
        exp_t e;
        int s;
        forever begin
            @(posedge clk);
            if (rst) ecount = 0;
            else ecount++;
            @(negedge clk);
            if (rst) begin
                cur_slot = 0;
            end else if (ecount >= 2 && ecount % 4 == 2) begin
                s = (ecount - 2) / 4;
                cur_slot = s;
                while (sbq.size() > 0 && sbq[0].slot < s) begin
                    e = sbq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed slot %0d: now %0d", e.slot, s);
                end
                if (sbq.size() > 0 && sbq[0].slot == s) begin
                    e = sbq.pop_front();
                    checks++;
                    if (AN !== e.an || cathode !== e.cath) begin
                        errors++;
                        $display("FAIL slot %0d: AN=%h cath=%h expected AN=%h cath=%h",
                                 s, AN, cathode, e.an, e.cath);
                    end
                end
            end
        end
    end

    // Busy monitor: every completed conversion holds busy 15 cycles
    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else if (busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                checks++;
                if (run != VAL_W + 1) begin
                    errors++;
                    $display("FAIL busy_len: got %0d expected %0d",
                             run, VAL_W + 1);
                end
                run = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                    7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};
        vecs[0] = '{567,  1234,  2'b00, 2'b00, 32'h1234_0567, 1};
        vecs[1] = '{7,    1234,  2'b01, 2'b00, 32'h1234_AAA7, 1};
        vecs[2] = '{0,    50,    2'b11, 2'b00, 32'hAA50_AAA0, 1};
        vecs[3] = '{305,  16383, 2'b01, 2'b00, 32'h9999_A305, 1};
        vecs[4] = '{9999, 10000, 2'b10, 2'b00, 32'h9999_9999, 1};
        vecs[5] = '{4321, 8,     2'b10, 2'b10, 32'hAAA8_4321, 4};

        rst      = 1'b1;
        values   = '0;
        blank_lz = '0;
        blink    = '0;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(AN), 32'hFF);
        chk("rst_cath", 32'(cathode), 32'h7F);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        push(0, 8'hFF, 7'h7F);
        push(1, 8'hFD, 7'h40);
        drain();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        values   = {14'd1234, 14'd567};
        blank_lz = 2'b00;
        blink    = 2'b00;
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_seen", 32'(busy), 32'h1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", 32'(AN), 32'hFF);
        chk("mid_rst_cath", 32'(cathode), 32'h7F);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(0, 8'hFF, 7'h7F);
        push(1, 8'hFD, 7'h40);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] one;
            logic [31:0] dg;
            one = 8'h01 << k;
            dg  = 32'h1234_0567;
            push(16 + k, ~one, seg_tab[dg[4*k +: 4]]);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
